vs_tx_arbiter: RTL and testbench

VS_TX_ARBITER -- requirements
Module: vs_tx_arbiter

---
 rtl/vs_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_vs_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs_tx_arbiter.sv
// vs_tx_arbiter
// Two-requester byte-stream arbiter in front of a UART transmitter.
// A grant is held for a whole message (until a byte flagged LAST is sent).
// Ties in IDLE are broken round-robin against the previous owner.
// Each byte takes three cycles: OWN (accept), STB (load strobe) and GAP
// (the transmitter's idle flag is not trusted yet).
// Optional feature macro: VS_TX_ARB_TIMEOUT_EN. When it is defined, an owner
// that keeps its VALID low for TIMEOUT cycles in OWN loses the grant and
// TO_ERR pulses. When it is undefined, TO_ERR is tied low and an owner may
// stall forever.
module vs_tx_arbiter #(
    parameter int TIMEOUT = 1000
) (
    input  logic       CLK,
    input  logic       SYS_NRST,
    input  logic       R0_VALID,
    input  logic [7:0] R0_DATA,
    input  logic       R0_LAST,
    output logic       R0_READY,
    input  logic       R1_VALID,
    input  logic [7:0] R1_DATA,
    input  logic       R1_LAST,
    output logic       R1_READY,
    input  logic       TX_RDY,
    output logic [7:0] TX_DATA,
    output logic       TX_STB,
    output logic [1:0] GNT,
    output logic       BUSY,
    output logic       TO_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_STB  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // A zero timeout would release an owner before it could ever stall.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("vs_tx_arbiter: TIMEOUT must be at least 1");
    end

    // One-hot grant vector for requester index idx.
    function automatic logic [1:0] grant_vec(input logic idx);
        grant_vec = idx ? 2'b10 : 2'b01;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  gnt_r;
    logic        busy_r;
    logic [7:0]  tx_data_r;
    logic        tx_stb_r;
    logic        last_flag_r;
    logic        last_owner_r;
    logic        to_err_r;

    logic        own_valid_s;
    logic [7:0]  own_data_s;
    logic        own_last_s;
    logic        owner_idx_s;
    logic        req_any_s;
    logic        winner_s;
    logic        accept_s;
    logic        timeout_hit_s;
    logic        r0_ready_s;
    logic        r1_ready_s;

    // Select the current owner's stream; nothing is selected without a grant.
    always_comb begin
        own_valid_s = 1'b0;
        own_data_s  = 8'h00;
        own_last_s  = 1'b0;
        owner_idx_s = 1'b0;
        if (gnt_r[1]) begin
            own_valid_s = R1_VALID;
            own_data_s  = R1_DATA;
            own_last_s  = R1_LAST;
            owner_idx_s = 1'b1;
        end else if (gnt_r[0]) begin
            own_valid_s = R0_VALID;
            own_data_s  = R0_DATA;
            own_last_s  = R0_LAST;
            owner_idx_s = 1'b0;
        end else begin
            own_valid_s = 1'b0;
            own_data_s  = 8'h00;
            own_last_s  = 1'b0;
            owner_idx_s = 1'b0;
        end
    end

    // Round-robin winner: on a tie the requester that did not own last wins.
    always_comb begin
        req_any_s = R0_VALID | R1_VALID;
        winner_s  = 1'b0;
        if (R0_VALID && R1_VALID) begin
            winner_s = ~last_owner_r;
        end else if (R1_VALID) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign accept_s = (state_r == ST_OWN) && own_valid_s && TX_RDY;

`ifdef VS_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt_r;

    // The stall that would make the count reach TIMEOUT releases the grant.
    assign timeout_hit_s = (state_r == ST_OWN) && !own_valid_s && (to_cnt_r == CNT_LIMIT);

    // Count consecutive owner-stall cycles in OWN; any VALID or other state clears.
    always_ff @(posedge CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            to_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_OWN) && !own_valid_s && !timeout_hit_s) begin
            to_cnt_r <= to_cnt_r + CNT_ONE;
        end else begin
            to_cnt_r <= CNT_ZERO;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_s = ST_OWN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (timeout_hit_s) begin
                    state_s = ST_IDLE;
                end else if (accept_s) begin
                    state_s = ST_STB;
                end else begin
                    state_s = ST_OWN;
                end
            end
            ST_STB: begin
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (last_flag_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OWN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Combinational READY: only the owner, only in OWN, only with the transmitter idle.
    always_comb begin
        r0_ready_s = 1'b0;
        r1_ready_s = 1'b0;
        if (accept_s) begin
            r0_ready_s = ~owner_idx_s;
            r1_ready_s = owner_idx_s;
        end else begin
            r0_ready_s = 1'b0;
            r1_ready_s = 1'b0;
        end
    end

    // Grant, byte latch, strobe and timeout pulse registers.
    always_ff @(posedge CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            gnt_r        <= 2'b00;
            busy_r       <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_stb_r     <= 1'b0;
            last_flag_r  <= 1'b0;
            last_owner_r <= 1'b1;
            to_err_r     <= 1'b0;
        end else begin
            tx_stb_r <= accept_s;
            to_err_r <= timeout_hit_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        gnt_r  <= grant_vec(winner_s);
                        busy_r <= 1'b1;
                    end
                end
                ST_OWN: begin
                    if (timeout_hit_s) begin
                        gnt_r        <= 2'b00;
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_idx_s;
                    end else if (accept_s) begin
                        tx_data_r   <= own_data_s;
                        last_flag_r <= own_last_s;
                    end
                end
                ST_STB: begin
                    gnt_r <= gnt_r;
                end
                ST_GAP: begin
                    if (last_flag_r) begin
                        gnt_r        <= 2'b00;
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_idx_s;
                    end
                end
                default: begin
                    gnt_r  <= 2'b00;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign R0_READY = r0_ready_s;
    assign R1_READY = r1_ready_s;
    assign TX_DATA  = tx_data_r;
    assign TX_STB   = tx_stb_r;
    assign GNT      = gnt_r;
    assign BUSY     = busy_r;
    assign TO_ERR   = to_err_r;

endmodule

// File: tb/tb_vs_tx_arbiter.sv
// Testbench for vs_tx_arbiter: directed scenarios plus a randomized phase.
// Expected bytes go into a scoreboard queue when stimulus is planned; a
// monitor pops and compares on every TX_STB. In the random phase both
// requesters always have a message pending, so the transmitted stream must be
// whole messages strictly alternating R0, R1, R0, ...
`timescale 1ns/1ps
module tb_vs_tx_arbiter;

    logic       CLK = 1'b0;
    logic       SYS_NRST;
    logic       R0_VALID, R0_LAST, R1_VALID, R1_LAST, TX_RDY;
    logic [7:0] R0_DATA, R1_DATA;
    logic       R0_READY, R1_READY, TX_STB, BUSY, TO_ERR;
    logic [7:0] TX_DATA;
    logic [1:0] GNT;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_stb = -100;
    bit rand_run = 1'b0;

    logic [7:0] exp_q[$];
    int         stb_times[$];
    int         to_err_times[$];
    logic [8:0] stim0[$];
    logic [8:0] stim1[$];

    vs_tx_arbiter #(.TIMEOUT(10)) dut (
        .CLK      (CLK),
        .SYS_NRST (SYS_NRST),
        .R0_VALID (R0_VALID),
        .R0_DATA  (R0_DATA),
        .R0_LAST  (R0_LAST),
        .R0_READY (R0_READY),
        .R1_VALID (R1_VALID),
        .R1_DATA  (R1_DATA),
        .R1_LAST  (R1_LAST),
        .R1_READY (R1_READY),
        .TX_RDY   (TX_RDY),
        .TX_DATA  (TX_DATA),
        .TX_STB   (TX_STB),
        .GNT      (GNT),
        .BUSY     (BUSY),
        .TO_ERR   (TO_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 0) begin
            R0_VALID = v; R0_DATA = d; R0_LAST = l;
        end else begin
            R1_VALID = v; R1_DATA = d; R1_LAST = l;
        end
    endtask

    // Requester model: present each queued byte until accepted, with optional
    // random VALID stalls inside a message (never before a message's first byte).
    task automatic drive(input int id, input int stall_max);
        logic [8:0] b;
        bit acc;
        int budget;
        int k;
        while ((id == 0) ? (stim0.size() > 0) : (stim1.size() > 0)) begin
            b = (id == 0) ? stim0.pop_front() : stim1.pop_front();
            set_req(id, 1'b1, b[7:0], b[8]);
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge CLK);
                acc = (id == 0) ? (R0_VALID && R0_READY) : (R1_VALID && R1_READY);
                budget++;
                if (!acc && budget > 500) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL handshake_timeout: requester %0d got no READY in 500 cycles, expected acceptance", id);
                    if (id == 0) stim0.delete(); else stim1.delete();
                    acc = 1'b1;
                end
            end
            @(posedge CLK);
            #1;
            if (!b[8] && stall_max > 0) begin
                k = $urandom_range(0, stall_max);
                if (k > 0) begin
                    set_req(id, 1'b0, 8'($urandom), 1'b0);
                    tick(k);
                end
            end
        end
        set_req(id, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: structural invariants every cycle and scoreboard on each strobe.
    always @(negedge CLK) begin
        if (SYS_NRST) begin
            check("busy_eq_or_gnt", 32'(BUSY), 32'(|GNT));
            check("gnt_not_both", 32'(GNT == 2'b11), 32'd0);
            check("ready_only_owner", 32'((R0_READY && !GNT[0]) || (R1_READY && !GNT[1])), 32'd0);
            check("ready_needs_tx_rdy", 32'((R0_READY || R1_READY) && !TX_RDY), 32'd0);
`ifdef VS_TX_ARB_TIMEOUT_EN
            if (TO_ERR) begin
                to_err_times.push_back(cyc);
                check("gnt_on_timeout", 32'(GNT), 32'd0);
            end
`else
            check("to_err_tied_low", 32'(TO_ERR), 32'd0);
`endif
            if (TX_STB) begin
                stb_times.push_back(cyc);
                check("stb_spacing_ge3", 32'((cyc - last_stb) >= 3), 32'd1);
                last_stb = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stb_unexpected: got strobe with data %0h, expected no strobe", TX_DATA);
                end else begin
                    check("tx_data", 32'(TX_DATA), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        int bad;
        int len;
        logic [7:0] d;
        SYS_NRST = 1'b0;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        TX_RDY = 1'b0;

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_gnt", 32'(GNT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_tx_stb", 32'(TX_STB), 32'd0);
        check("rst_tx_data", 32'(TX_DATA), 32'h00);
        check("rst_to_err", 32'(TO_ERR), 32'd0);
        check("rst_r0_ready", 32'(R0_READY), 32'd0);
        check("rst_r1_ready", 32'(R1_READY), 32'd0);
        @(posedge CLK);
        #1 SYS_NRST = 1'b1;
        tick(2);

        // Three-byte message from R0 with the transmitter always idle.
        TX_RDY = 1'b1;
        stim0.push_back(9'h041); stim0.push_back(9'h042); stim0.push_back(9'h143);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        base = stb_times.size();
        drive(0, 0);
        tick(4);
        check("msg3_gnt_released", 32'(GNT), 32'd0);
        check("msg3_strobes", 32'(stb_times.size() - base), 32'd3);
        if (stb_times.size() - base >= 3) begin
            check("msg3_gap_1_2", 32'(stb_times[base+1] - stb_times[base]), 32'd3);
            check("msg3_gap_2_3", 32'(stb_times[base+2] - stb_times[base+1]), 32'd3);
        end

        // Transmitter busy for 20 cycles while R0 owns: no READY, no strobe.
        TX_RDY = 1'b0;
        set_req(0, 1'b1, 8'h5A, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (R0_READY !== 1'b0) bad++;
        end
        check("stall_no_ready", 32'(bad), 32'd0);
        check("stall_gnt_r0", 32'(GNT), 32'd1);
        @(posedge CLK);
        #1 TX_RDY = 1'b1;
        c = cyc;
        exp_q.push_back(8'h5A);
        base = stb_times.size();
        @(negedge CLK);
        check("ready_after_rdy", 32'(R0_READY), 32'd1);
        @(posedge CLK);
        #1 set_req(0, 1'b0, 8'h00, 1'b0);
        tick(4);
        check("stall_strobes", 32'(stb_times.size() - base), 32'd1);
        if (stb_times.size() - base >= 1) begin
            check("stall_strobe_time", 32'(stb_times[base]), 32'(c + 1));
        end

`ifdef VS_TX_ARB_TIMEOUT_EN
        // Owner abandons its message after one byte; R1 waits and is granted after the timeout.
        begin
            int tbase;
            tbase = to_err_times.size();
            base = stb_times.size();
            exp_q.push_back(8'h01);
            exp_q.push_back(8'hB1);
            stim0.push_back(9'h001);
            drive(0, 0);
            stim1.push_back(9'h1B1);
            drive(1, 0);
            tick(4);
            check("to_pulses", 32'(to_err_times.size() - tbase), 32'd1);
            check("to_strobes", 32'(stb_times.size() - base), 32'd2);
            if ((to_err_times.size() - tbase >= 1) && (stb_times.size() - base >= 2)) begin
                check("to_time", 32'(to_err_times[tbase]), 32'(stb_times[base] + 12));
                check("to_r1_after", 32'(stb_times[base+1] > to_err_times[tbase]), 32'd1);
            end
        end
`endif

        // Reset pulsed while a strobe is on the wire: the message is abandoned.
        TX_RDY = 1'b1;
        set_req(0, 1'b1, 8'h77, 1'b0);
        exp_q.push_back(8'h77);
        bad = 1;
        for (int i = 0; i < 50 && bad != 0; i++) begin
            @(negedge CLK);
            if (TX_STB === 1'b1) bad = 0;
        end
        check("rst_mid_stb_seen", 32'(bad), 32'd0);
        #2 SYS_NRST = 1'b0;
        #1;
        check("rst_mid_tx_stb", 32'(TX_STB), 32'd0);
        check("rst_mid_gnt", 32'(GNT), 32'd0);
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(posedge CLK);
        #1 SYS_NRST = 1'b1;
        tick(8);
        check("rst_mid_idle_gnt", 32'(GNT), 32'd0);
        stim1.push_back(9'h1C3);
        exp_q.push_back(8'hC3);
        drive(1, 0);
        tick(4);
        check("rst_mid_regrant", 32'(exp_q.size()), 32'd0);

        // Randomized phase: both requesters always pending, random stalls and TX_RDY.
        @(posedge CLK);
        #1 SYS_NRST = 1'b0;
        tick(2);
        SYS_NRST = 1'b1;
        tick(2);
        for (int m = 0; m < 6; m++) begin
            for (int r = 0; r < 2; r++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    if (r == 0) stim0.push_back({(j == len - 1) ? 1'b1 : 1'b0, d});
                    else        stim1.push_back({(j == len - 1) ? 1'b1 : 1'b0, d});
                end
            end
        end
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    @(posedge CLK);
                    #1 TX_RDY = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        fork
            drive(0, 3);
            drive(1, 3);
        join
        rand_run = 1'b0;
        tick(3);
        TX_RDY = 1'b1;
        tick(8);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_gnt_idle", 32'(GNT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
